// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared op-code and state encodings for the ALU issue block.
//               Also provides small helpers that classify op-codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Operation codes (result = b op a). Codes 0 and 7 are illegal.
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_MOD = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;

  // Issue state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  function automatic logic op_is_divide(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Single-outstanding issue stage in front of an external
//               combinational ALU. Latches a request, drives the ALU for one
//               EXEC cycle, captures the result and holds it until consumed.
//               Illegal op-codes bypass the ALU and return an error response.
// Config      : ALU_ISSUE_DIV_GUARD_EN - when defined, div/mod with a==0 is
//               answered directly with all-ones data and an error flag.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               req_*            - request handshake and operands
//               alu_in1/in2/op   - operands/op-code to the ALU
//               alu_out          - ALU result
//               rsp_*            - response handshake, data and flags
//               busy             - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  output logic              rsp_err,
  output logic              busy
);

  logic [1:0]        state;
  logic [2:0]        lat_op;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;

  // Negative-or-zero flag, always derived from the value being captured
  function automatic logic neg_or_zero(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] | (v == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      lat_op   <= 3'd0;
      lat_a    <= '0;
      lat_b    <= '0;
      rsp_data <= '0;
      rsp_z    <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_op <= req_op;
            lat_a  <= req_a;
            lat_b  <= req_b;
            if (!op_is_legal(req_op)) begin
              state    <= ST_RESP;
              rsp_data <= '0;
              rsp_z    <= neg_or_zero('0);
              rsp_err  <= 1'b1;
            end
`ifdef ALU_ISSUE_DIV_GUARD_EN
            // req_a is the divisor, since the ALU computes b op a
            else if (op_is_divide(req_op) && (req_a == '0)) begin
              state    <= ST_RESP;
              rsp_data <= '1;
              rsp_z    <= neg_or_zero('1);
              rsp_err  <= 1'b1;
            end
`endif
            else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          state    <= ST_RESP;
          rsp_data <= alu_out;
          rsp_z    <= neg_or_zero(alu_out);
          rsp_err  <= 1'b0;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // Operands hold their last latched value; the op-code is only presented
  // during EXEC so the ALU sees a no-op otherwise.
  assign alu_in1 = lat_a;
  assign alu_in2 = lat_b;
  assign alu_op  = (state == ST_EXEC) ? lat_op : 3'd0;

endmodule
`default_nettype wire
